// File: rtl/stl_uart_router.sv
// Byte front end between UART RX/TX and the SerialTL byte FIFO port.
// RX frames header+payload packets into a commit/rollback FIFO; TX prefixes each response with the header.
module stl_uart_router #(
    parameter int         CLOCK_FREQ = 100_000_000,
    parameter int         TIMEOUT_US = 1000,
    parameter int         FIFO_DEPTH = 32,
    parameter int         PKT_BYTES  = 16,
    parameter logic [7:0] HDR_STL    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       stl_valid,
    input  logic       stl_ready,
    output logic [7:0] stl_data,
    input  logic       rsp_valid,
    output logic       rsp_ready,
    input  logic [7:0] rsp_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       overflow,
    output logic       timeout_err,
    output logic       bad_hdr
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam int TO_CYC = CLOCK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC + 1);
    localparam int CW     = $clog2(PKT_BYTES + 1);

    typedef enum logic       {R_IDLE, R_PAY}          rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_BODY}  tx_state_t;

    rx_state_t     rx_state, rx_next;
    tx_state_t     tx_state, tx_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
    logic [CW-1:0] pay_cnt, body_cnt;
    logic [TW-1:0] to_cnt;
    logic          full, rd_fire, tx_fire;
    logic          do_start, do_write, do_commit, do_rollback, hdr_err, to_hit, ovf_hit;

    // Only committed bytes are visible; the write pointer runs ahead of the commit pointer.
    assign full      = (wr_ptr - rd_ptr) == PW'(FIFO_DEPTH);
    assign stl_valid = cm_ptr != rd_ptr;
    assign stl_data  = stl_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign rd_fire   = stl_valid && stl_ready;

    always_comb begin
        rx_next     = rx_state;
        do_start    = 1'b0;
        do_write    = 1'b0;
        do_commit   = 1'b0;
        do_rollback = 1'b0;
        hdr_err     = 1'b0;
        to_hit      = 1'b0;
        ovf_hit     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == HDR_STL) begin
                        do_start = 1'b1;
                        rx_next  = R_PAY;
                    end else begin
                        hdr_err = 1'b1;
                    end
                end
            end
            R_PAY: begin
                if (rx_valid) begin
                    if (full) begin
                        ovf_hit     = 1'b1;
                        do_rollback = 1'b1;
                        rx_next     = R_IDLE;
                    end else begin
                        do_write = 1'b1;
                        if (pay_cnt == CW'(PKT_BYTES - 1)) begin
                            do_commit = 1'b1;
                            rx_next   = R_IDLE;
                        end
                    end
                end else if (to_cnt == TW'(TO_CYC - 1)) begin
                    to_hit      = 1'b1;
                    do_rollback = 1'b1;
                    rx_next     = R_IDLE;
                end
            end
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state    <= R_IDLE;
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            rd_ptr      <= '0;
            pay_cnt     <= '0;
            to_cnt      <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            bad_hdr     <= 1'b0;
        end else begin
            rx_state    <= rx_next;
            timeout_err <= to_hit;
            bad_hdr     <= hdr_err;
            if (ovf_hit)
                overflow <= 1'b1;
            if (do_start) begin
                pay_cnt <= '0;
                to_cnt  <= '0;
            end else if (do_write) begin
                pay_cnt <= pay_cnt + 1'b1;
                to_cnt  <= '0;
            end else if (rx_state == R_PAY) begin
                to_cnt <= to_cnt + 1'b1;
            end
            // Rollback only rewinds the write side; committed data and rd_ptr are untouched.
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            else if (do_rollback)
                wr_ptr <= cm_ptr;
            if (do_commit)
                cm_ptr <= wr_ptr + 1'b1;
            if (rd_fire)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr[AW-1:0]] <= rx_data;
    end

    // The body phase is a pure pass-through so response bytes see no added latency.
    assign tx_fire = (tx_state == T_BODY) && rsp_valid && tx_ready;

    always_comb begin
        tx_next   = tx_state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rsp_ready = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (rsp_valid)
                    tx_next = T_HDR;
            end
            T_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_STL;
                if (tx_ready)
                    tx_next = T_BODY;
            end
            T_BODY: begin
                tx_valid  = rsp_valid;
                tx_data   = rsp_data;
                rsp_ready = tx_ready;
                if (tx_fire && body_cnt == CW'(PKT_BYTES - 1))
                    tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= T_IDLE;
            body_cnt <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == T_HDR && tx_ready)
                body_cnt <= '0;
            else if (tx_fire)
                body_cnt <= body_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_stl_uart_router.sv
// Self-checking bench for stl_uart_router: directed scenarios plus randomized traffic
// against a queue-based packet model of the RX and TX paths.
module tb_stl_uart_router;
    localparam int         FIFO_DEPTH = 32;
    localparam int         PKT        = 16;
    localparam int         TO_CYC     = 100;
    localparam logic [7:0] HDR        = 8'hA5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       stl_valid, stl_ready;
    logic [7:0] stl_data;
    logic       rsp_valid = 1'b0;
    logic       rsp_ready;
    logic [7:0] rsp_data = 8'h00;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       overflow, timeout_err, bad_hdr;

    stl_uart_router #(
        .CLOCK_FREQ(100_000_000), .TIMEOUT_US(1), .FIFO_DEPTH(FIFO_DEPTH),
        .PKT_BYTES(PKT), .HDR_STL(HDR)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .stl_valid(stl_valid), .stl_ready(stl_ready), .stl_data(stl_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .overflow(overflow), .timeout_err(timeout_err), .bad_hdr(bad_hdr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Packet-level model: committed bytes awaiting delivery, bytes of the packet in flight.
    logic [7:0] exp_q[$];
    logic [7:0] pend[$];
    logic [7:0] tx_exp[$];
    bit  in_pkt = 0;
    bit  exp_ovf = 0;
    bit  rd_pend = 0;
    bit  tx_stall = 0;
    logic [7:0] stall_data = 8'h00;
    int  idle_cnt = 0;
    int  exp_to = 0, got_to = 0, exp_bad = 0, got_bad = 0;
    int  n_rd = 0, n_tx = 0;
    int  stl_mode = 0;

    task automatic model_clear();
        exp_q.delete();
        pend.delete();
        tx_exp.delete();
        in_pkt   = 0;
        exp_ovf  = 0;
        rd_pend  = 0;
        idle_cnt = 0;
    endtask

    always @(posedge clk) begin
        if (!reset_n) begin
            model_clear();
        end else begin
            if (rx_valid) begin
                if (!in_pkt) begin
                    if (rx_data == HDR) begin
                        in_pkt = 1;
                        idle_cnt = 0;
                        pend.delete();
                    end else begin
                        exp_bad++;
                    end
                end else if (exp_q.size() + pend.size() >= FIFO_DEPTH) begin
                    exp_ovf = 1;
                    pend.delete();
                    in_pkt = 0;
                end else begin
                    pend.push_back(rx_data);
                    idle_cnt = 0;
                    if (pend.size() == PKT) begin
                        foreach (pend[i]) exp_q.push_back(pend[i]);
                        pend.delete();
                        in_pkt = 0;
                    end
                end
            end else if (in_pkt) begin
                idle_cnt++;
                if (idle_cnt == TO_CYC) begin
                    exp_to++;
                    pend.delete();
                    in_pkt = 0;
                end
            end
            if (rd_pend && exp_q.size() != 0)
                exp_q.delete(0);
            rd_pend = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("stl_valid", stl_valid, exp_q.size() != 0);
            checkOutput("overflow", overflow, exp_ovf);
            rd_pend = 0;
            if (stl_valid && stl_ready) begin
                checkOutput("stl_data", {1'b0, stl_data}, exp_q.size() != 0 ? {1'b0, exp_q[0]} : 9'h1FF);
                rd_pend = 1;
                n_rd++;
            end
            if (timeout_err) got_to++;
            if (bad_hdr) got_bad++;
            if (tx_stall)
                checkOutput("tx_hold", {tx_valid, tx_data}, {1'b1, stall_data});
            if (tx_valid && tx_ready) begin
                n_tx++;
                checkOutput("tx_data", {1'b0, tx_data}, tx_exp.size() != 0 ? {1'b0, tx_exp.pop_front()} : 9'h1FF);
            end
            tx_stall   = tx_valid && !tx_ready;
            stall_data = tx_data;
        end else begin
            rd_pend  = 0;
            tx_stall = 0;
        end
    end

    initial begin
        stl_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (stl_mode)
                0:       stl_ready = 1'b1;
                1:       stl_ready = 1'b0;
                default: stl_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick(gap);
    endtask

    function automatic int rnd_gap(input int mode);
        if (mode == 0) return 0;
        if ($urandom_range(0, 15) == 0) return 98 + int'($urandom_range(0, 3));
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base, input int n,
                            input bit rnd_data, input int gap_mode);
        applyStimulus(hdr, rnd_gap(gap_mode));
        for (int i = 0; i < n; i++)
            applyStimulus(rnd_data ? 8'($urandom) : base + 8'(i), rnd_gap(gap_mode));
    endtask

    // mode 0: tx_ready always 1, 1: toggles 1010..., 2: random
    task automatic send_rsp(input logic [7:0] base, input int n, input int mode);
        int  cyc = 0;
        int  sent = 0;
        bit  hs;
        tx_exp.push_back(HDR);
        for (int i = 0; i < n; i++) tx_exp.push_back(base + 8'(i));
        rsp_valid = 1'b1;
        rsp_data  = base;
        while (sent < n && cyc < 2000) begin
            tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = rsp_valid && rsp_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                sent++;
                rsp_data = base + 8'(sent);
                if (sent == n) rsp_valid = 1'b0;
            end
        end
        tx_ready  = 1'b0;
        rsp_valid = 1'b0;
        if (sent < n) checkOutput("rsp_budget", sent, n);
    endtask

    task automatic wait_drain(input string tag);
        int c = 0;
        while ((exp_q.size() != 0 || in_pkt) && c < 1000) begin
            tick(1);
            c++;
        end
        checkOutput(tag, exp_q.size(), 0);
        tick(3);
    endtask

    task automatic check_pulses(input string tag);
        checkOutput({tag, "_timeouts"}, got_to, exp_to);
        checkOutput({tag, "_bad_hdrs"}, got_bad, exp_bad);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_outs"},
                    {stl_valid, stl_data, rsp_ready, tx_valid, tx_data, overflow, timeout_err, bad_hdr},
                    32'h0);
    endtask

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0, t0, b0, x0;
        model_clear();
        tick(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(2);

        // 1: single clean packet
        r0 = n_rd;
        stl_mode = 0;
        send_pkt(HDR, 8'h00, PKT, 0, 0);
        wait_drain("t1_drain");
        checkOutput("t1_count", n_rd - r0, PKT);
        check_pulses("t1");

        // 2: inter-byte gap of TO_CYC-1 survives, gap of TO_CYC aborts
        r0 = n_rd; t0 = got_to;
        applyStimulus(HDR, 0);
        for (int i = 0; i < 8; i++) applyStimulus(8'h20 + 8'(i), 0);
        tick(TO_CYC - 1);
        for (int i = 8; i < PKT; i++) applyStimulus(8'h20 + 8'(i), 0);
        wait_drain("t2a_drain");
        checkOutput("t2a_no_timeout", got_to - t0, 0);
        checkOutput("t2a_count", n_rd - r0, PKT);
        r0 = n_rd;
        send_pkt(HDR, 8'h30, 8, 0, 0);
        tick(TO_CYC + 20);
        checkOutput("t2b_one_timeout", got_to - t0, 1);
        checkOutput("t2b_nothing_out", n_rd - r0, 0);
        send_pkt(HDR, 8'h40, PKT, 0, 0);
        wait_drain("t2c_drain");
        checkOutput("t2c_count", n_rd - r0, PKT);
        check_pulses("t2");

        // 3: fill the FIFO with two packets, third overflows
        r0 = n_rd;
        stl_mode = 1;
        tick(1);
        send_pkt(HDR, 8'h50, PKT, 0, 0);
        send_pkt(HDR, 8'h60, PKT, 0, 0);
        send_pkt(HDR, 8'h70, 1, 0, 0);
        tick(2);
        checkOutput("t3_overflow", overflow, 1);
        checkOutput("t3_held", n_rd - r0, 0);
        stl_mode = 0;
        wait_drain("t3_drain");
        checkOutput("t3_count", n_rd - r0, 2 * PKT);
        check_pulses("t3");

        // 4: stray byte before header
        r0 = n_rd; b0 = got_bad;
        applyStimulus(8'h3C, 1);
        send_pkt(HDR, 8'h80, PKT, 1, 0);
        wait_drain("t4_drain");
        checkOutput("t4_bad_hdr", got_bad - b0, 1);
        checkOutput("t4_count", n_rd - r0, PKT);

        // 5: response with toggling tx_ready, concurrent with an RX packet
        x0 = n_tx; r0 = n_rd;
        fork
            send_rsp(8'h10, PKT, 1);
            send_pkt(HDR, 8'h90, PKT, 0, 0);
        join
        tick(3);
        checkOutput("t5_tx_handshakes", n_tx - x0, PKT + 1);
        checkOutput("t5_tx_left", tx_exp.size(), 0);
        wait_drain("t5_drain");
        checkOutput("t5_count", n_rd - r0, PKT);
        check_pulses("t5");

        // 6: reset mid-packet and mid-response
        send_rsp(8'hC0, 5, 0);
        rsp_valid = 1'b1;
        rsp_data  = 8'hC5;
        tx_ready  = 1'b0;
        stl_mode  = 1;
        send_pkt(HDR, 8'hD0, 5, 0, 0);
        checkOutput("t6_tx_pending", tx_valid, 1);
        reset_n = 1'b0;
        model_clear();
        #1;
        check_all_zero("t6_in_reset");
        rsp_valid = 1'b0;
        tick(2);
        reset_n = 1'b1;
        stl_mode = 0;
        tick(2);
        r0 = n_rd; x0 = n_tx;
        send_pkt(HDR, 8'hE0, PKT, 0, 0);
        send_rsp(8'hF0, PKT, 0);
        wait_drain("t6_drain");
        checkOutput("t6_count", n_rd - r0, PKT);
        checkOutput("t6_tx_handshakes", n_tx - x0, PKT + 1);
        check_pulses("t6");

        // randomized traffic: headers, gaps, backpressure on both sides
        stl_mode = 2;
        for (int p = 0; p < 12; p++) begin
            fork
                send_pkt(($urandom_range(0, 5) == 0) ? 8'($urandom) : HDR, 8'h00, PKT, 1, 1);
                send_rsp(8'($urandom), PKT, 2);
            join
        end
        stl_mode = 0;
        wait_drain("rnd_drain");
        checkOutput("rnd_tx_left", tx_exp.size(), 0);
        check_pulses("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
